// File: rtl/bias_fifo2core_rd.sv
// Core-side bias FIFO reader: drains one layer's worth of 40-bit bias words
// from the FIFO and hands each to the compute core over valid/ready.
module bias_fifo2core_rd #(
    parameter int unsigned MEM_SIZE = 40,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned L0_WORDS = 6,
    parameter int unsigned L1_WORDS = 12,
    parameter int unsigned L2_WORDS = 16,
    parameter int unsigned L3_WORDS = 10,
    parameter int unsigned L4_WORDS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          layer_signal_i,
    input  logic                start_i,
    input  logic [MEM_SIZE-1:0] fifo_dout_i,
    input  logic                empty_i,
    output logic                rd_en_o,
    output logic [MEM_SIZE-1:0] bias_out_o,
    output logic                bias_valid_o,
    input  logic                bias_ready_i,
    output logic                layer_done_o,
    output logic                busy_o,
    output logic                layer_err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLat,
        StOut,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [MEM_SIZE-1:0] bias_q, bias_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    layer_words;

    always_comb begin
        case (layer_signal_i)
            3'd0:    layer_words = CNT_W'(L0_WORDS);
            3'd1:    layer_words = CNT_W'(L1_WORDS);
            3'd2:    layer_words = CNT_W'(L2_WORDS);
            3'd3:    layer_words = CNT_W'(L3_WORDS);
            3'd4:    layer_words = CNT_W'(L4_WORDS);
            default: layer_words = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        bias_d       = bias_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        err_d        = err_q;
        rd_en_o      = 1'b0;
        layer_done_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (layer_signal_i <= 3'd4) begin
                        target_d = layer_words;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        err_d    = 1'b0;
                        state_d  = StReq;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StReq: begin
                // Never pop an empty FIFO; wait here until data shows up.
                if (!empty_i) begin
                    rd_en_o = 1'b1;
                    state_d = StLat;
                end
            end
            StLat: begin
                bias_d  = fifo_dout_i;
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (valid_q && bias_ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == target_q - CNT_W'(1)) ? StDone : StReq;
                end
            end
            StDone: begin
                layer_done_o = 1'b1;
                busy_d       = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            target_q <= '0;
            bias_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            bias_q   <= bias_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bias_out_o   = bias_q;
    assign bias_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign layer_err_o  = err_q;

endmodule

// File: tb/tb_bias_fifo2core_rd.sv
// Self-checking bench for bias_fifo2core_rd: FIFO model, per-cycle monitor and
// scenario tasks comparing against a word-order / word-count reference.
module tb_bias_fifo2core_rd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  layer = 3'd0;
    logic        start = 1'b0;
    logic [39:0] fifo_dout = '0;
    logic        empty;
    logic        rd_en;
    logic [39:0] bias_out;
    logic        bias_valid;
    logic        bias_ready = 1'b1;
    logic        layer_done;
    logic        busy;
    logic        layer_err;

    int checks = 0;
    int errors = 0;

    bias_fifo2core_rd dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .layer_signal_i (layer),
        .start_i        (start),
        .fifo_dout_i    (fifo_dout),
        .empty_i        (empty),
        .rd_en_o        (rd_en),
        .bias_out_o     (bias_out),
        .bias_valid_o   (bias_valid),
        .bias_ready_i   (bias_ready),
        .layer_done_o   (layer_done),
        .busy_o         (busy),
        .layer_err_o    (layer_err)
    );

    always #5 clk = ~clk;

    // Words per layer, straight from the layer table.
    int words_tbl [5] = '{6, 12, 16, 10, 5};

    // FIFO model: write side owned by the stimulus tasks, read side by the clock.
    logic [39:0] mem [0:1023];
    int          wp = 0;
    int          rp = 0;
    logic        force_empty = 1'b0;
    logic        flush = 1'b0;
    assign empty = force_empty || (rp == wp);

    always @(posedge clk) begin
        if (flush) rp <= wp;
        else if (rd_en && !empty) begin
            fifo_dout <= mem[rp];
            rp <= rp + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs pops, accepted words, done pulses and protocol violations.
    logic [39:0] acc_q [$];
    int          rd_cyc_q [$];
    int          done_cyc_q [$];
    int          bad_pop = 0;
    int          unstable = 0;
    logic        hold_prev = 1'b0;
    logic [39:0] prev_out = '0;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc_q.push_back(cyc);
            if (empty) bad_pop++;
        end
        if (bias_valid && bias_ready) acc_q.push_back(bias_out);
        if (hold_prev && (!bias_valid || bias_out !== prev_out)) unstable++;
        hold_prev = bias_valid && !bias_ready;
        prev_out  = bias_out;
        if (layer_done) done_cyc_q.push_back(cyc);
    end

    logic [39:0] exp_q [$];
    int          stall_cnt = 0;

    task automatic push_words(input int n);
        logic [63:0] r;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            r = {$urandom, $urandom};
            mem[wp] = r[39:0];
            exp_q.push_back(r[39:0]);
            wp = wp + 1;
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 stall 4 cycles on word index 3.
    // empty_mode: 0 none, 1 forced empty for 10 REQ cycles, 2 random gaps.
    task automatic run_layer(input int lyr, input int ready_mode, input int empty_mode,
                             input int restart_at, output int c0, output bit done_ok);
        int a0;
        int d0;
        a0 = acc_q.size();
        d0 = done_cyc_q.size();
        done_ok = 1'b0;
        stall_cnt = 0;
        @(posedge clk); #1;
        c0 = cyc;
        layer = 3'(lyr);
        for (int i = 0; i < 600; i++) begin
            start = (i == 0) || (i == restart_at);
            if (i == restart_at) layer = 3'd4;
            case (ready_mode)
                0: bias_ready = 1'b1;
                1: bias_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (acc_q.size() - a0 == 3 && bias_valid && stall_cnt < 4) begin
                        bias_ready = 1'b0;
                        stall_cnt++;
                    end else bias_ready = 1'b1;
                end
            endcase
            case (empty_mode)
                0: force_empty = 1'b0;
                1: force_empty = (i <= 10);
                default: force_empty = ($urandom_range(0, 3) == 0);
            endcase
            @(negedge clk);
            if (done_cyc_q.size() > d0) begin
                done_ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        force_empty = 1'b0;
        bias_ready = 1'b1;
        layer = 3'd0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rd_en, bias_valid, busy, layer_done, layer_err} !== 5'b0 || bias_out !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h expected 00000/0",
                     {rd_en, bias_valid, busy, layer_done, layer_err}, bias_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b rd_en=%b expected 0/0", busy, rd_en);
        end
    endtask

    task automatic test_reset_mid_out();
        int  d0;
        bit  seen;
        push_words(6);
        d0 = done_cyc_q.size();
        seen = 1'b0;
        @(posedge clk); #1;
        layer = 3'd0;
        start = 1'b1;
        bias_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bias_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t1_reach_out: got bias_valid=0 expected 1 within 20 cycles");
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, bias_valid, busy, layer_done} !== 4'b0) begin
            errors++;
            $display("FAIL t1_async_reset: got %b expected 0000",
                     {rd_en, bias_valid, busy, layer_done});
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bias_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cyc_q.size() != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_no_done_after_reset: got done=%0d busy=%b expected 0/0",
                     done_cyc_q.size() - d0, busy);
        end
    endtask

    task automatic test_full_rate();
        int a0, r0, d0, c0, bad;
        bit ok;
        a0 = acc_q.size(); r0 = rd_cyc_q.size(); d0 = done_cyc_q.size();
        push_words(5);
        run_layer(4, 0, 0, -1, c0, ok);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int k = 0; k < 5; k++)
            if (acc_q.size() <= a0 + k || acc_q[a0 + k] !== exp_q[k]) bad++;
        checks++;
        if (bad != 0 || acc_q.size() - a0 != 5) begin
            errors++;
            $display("FAIL t2_words: got %0d words (%0d wrong) expected 5 in order",
                     acc_q.size() - a0, bad);
        end
        checks++;
        if (rd_cyc_q.size() - r0 != 5) begin
            errors++;
            $display("FAIL t2_pops: got %0d expected 5", rd_cyc_q.size() - r0);
        end
        checks++;
        if (!ok || done_cyc_q.size() - d0 != 1 || done_cyc_q[d0] - c0 != 16) begin
            errors++;
            $display("FAIL t2_done_timing: got %0d done, latency %0d expected 1, 16",
                     done_cyc_q.size() - d0, ok ? done_cyc_q[d0] - c0 : -1);
        end
    endtask

    task automatic test_backpressure();
        int a0, r0, u0, c0, bad;
        bit ok;
        a0 = acc_q.size(); r0 = rd_cyc_q.size(); u0 = unstable;
        push_words(16);
        run_layer(2, 2, 0, -1, c0, ok);
        bad = 0;
        for (int k = 0; k < 16; k++)
            if (acc_q.size() <= a0 + k || acc_q[a0 + k] !== exp_q[k]) bad++;
        checks++;
        if (!ok || bad != 0 || acc_q.size() - a0 != 16) begin
            errors++;
            $display("FAIL t3_words: got %0d words (%0d wrong) expected 16",
                     acc_q.size() - a0, bad);
        end
        checks++;
        if (stall_cnt != 4 || unstable != u0) begin
            errors++;
            $display("FAIL t3_stable: got stalls=%0d unstable=%0d expected 4/0",
                     stall_cnt, unstable - u0);
        end
        checks++;
        if (rd_cyc_q.size() - r0 != 16) begin
            errors++;
            $display("FAIL t3_pops: got %0d expected 16", rd_cyc_q.size() - r0);
        end
    endtask

    task automatic test_empty_hold();
        int a0, r0, b0, c0;
        bit ok;
        a0 = acc_q.size(); r0 = rd_cyc_q.size(); b0 = bad_pop;
        push_words(6);
        run_layer(0, 0, 1, -1, c0, ok);
        checks++;
        if (bad_pop != b0) begin
            errors++;
            $display("FAIL t4_pop_on_empty: got %0d expected 0", bad_pop - b0);
        end
        checks++;
        if (rd_cyc_q.size() <= r0 || rd_cyc_q[r0] != c0 + 11) begin
            errors++;
            $display("FAIL t4_resume: got first pop at %0d expected %0d",
                     rd_cyc_q.size() > r0 ? rd_cyc_q[r0] - c0 : -1, 11);
        end
        checks++;
        if (!ok || acc_q.size() - a0 != 6) begin
            errors++;
            $display("FAIL t4_words: got %0d expected 6", acc_q.size() - a0);
        end
    endtask

    task automatic test_bad_layer();
        int a0, r0, c0, bad;
        bit ok;
        r0 = rd_cyc_q.size();
        @(posedge clk); #1;
        layer = 3'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        layer = 3'd0;
        repeat (5) @(negedge clk);
        checks++;
        if (layer_err !== 1'b1 || busy !== 1'b0 || rd_cyc_q.size() != r0) begin
            errors++;
            $display("FAIL t5_err: got err=%b busy=%b pops=%0d expected 1/0/0",
                     layer_err, busy, rd_cyc_q.size() - r0);
        end
        a0 = acc_q.size();
        push_words(6);
        run_layer(0, 0, 0, -1, c0, ok);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (acc_q.size() <= a0 + k || acc_q[a0 + k] !== exp_q[k]) bad++;
        checks++;
        if (!ok || layer_err !== 1'b0 || bad != 0 || acc_q.size() - a0 != 6) begin
            errors++;
            $display("FAIL t5_recover: got err=%b words=%0d wrong=%0d expected 0/6/0",
                     layer_err, acc_q.size() - a0, bad);
        end
    endtask

    task automatic test_restart_ignored();
        int a0, r0, d0, c0, bad;
        bit ok;
        a0 = acc_q.size(); r0 = rd_cyc_q.size(); d0 = done_cyc_q.size();
        push_words(12);
        run_layer(1, 0, 0, 20, c0, ok);
        repeat (5) @(negedge clk);
        bad = 0;
        for (int k = 0; k < 12; k++)
            if (acc_q.size() <= a0 + k || acc_q[a0 + k] !== exp_q[k]) bad++;
        checks++;
        if (rd_cyc_q.size() - r0 != 12 || done_cyc_q.size() - d0 != 1) begin
            errors++;
            $display("FAIL t6_restart: got pops=%0d done=%0d expected 12/1",
                     rd_cyc_q.size() - r0, done_cyc_q.size() - d0);
        end
        checks++;
        if (!ok || bad != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_words: got wrong=%0d busy=%b expected 0/0", bad, busy);
        end
    endtask

    task automatic test_random();
        int lyr, n, a0, r0, b0, u0, c0, bad;
        bit ok;
        for (int it = 0; it < 12; it++) begin
            lyr = $urandom_range(0, 6);
            a0 = acc_q.size(); r0 = rd_cyc_q.size(); b0 = bad_pop; u0 = unstable;
            if (lyr > 4) begin
                @(posedge clk); #1;
                layer = 3'(lyr);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (3) @(negedge clk);
                checks++;
                if (layer_err !== 1'b1 || rd_cyc_q.size() != r0) begin
                    errors++;
                    $display("FAIL rnd_bad_layer %0d: got err=%b pops=%0d expected 1/0",
                             lyr, layer_err, rd_cyc_q.size() - r0);
                end
            end else begin
                n = words_tbl[lyr];
                push_words(n);
                run_layer(lyr, 1, 2, -1, c0, ok);
                bad = 0;
                for (int k = 0; k < n; k++)
                    if (acc_q.size() <= a0 + k || acc_q[a0 + k] !== exp_q[k]) bad++;
                checks++;
                if (!ok || bad != 0 || acc_q.size() - a0 != n || rd_cyc_q.size() - r0 != n ||
                    bad_pop != b0 || unstable != u0 || layer_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_layer %0d: got words=%0d pops=%0d wrong=%0d badpop=%0d unstable=%0d err=%b expected %0d/%0d/0/0/0/0",
                             lyr, acc_q.size() - a0, rd_cyc_q.size() - r0, bad,
                             bad_pop - b0, unstable - u0, layer_err, n, n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_out();
        test_full_rate();
        test_backpressure();
        test_empty_hold();
        test_bad_layer();
        test_restart_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
